gpu_core_param: RTL and testbench

//  Parametrised multicycle SIMT core, successor of the fixed 8-bit/16-entry core: loads a program into local

---
 rtl/gpu_core_param.sv | 248 ++++++++++++++++++++++++
 tb/tb_gpu_core_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_core_param.sv
// gpu_core_param: parametrised multicycle SIMT lane core.
// Loads a program into local IMEM while idle, then runs it through
// F-D-E-M-(MW)-WB against shared memory using a req/ack handshake.
// Optional feature macro: GPU_CORE_PERF_EN adds the perf_cycles output,
// a saturating count of the cycles spent executing (F..WB).
module gpu_core_param #(
    parameter int DW         = 8,
    parameter int AW         = 12,
    parameter int IMEM_DEPTH = 16,
    parameter int NCORES     = 16,
    parameter int CIDW       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CIDW-1:0]   core_id,
    input  logic              ins_valid,
    input  logic [15:0]       ins_data,
    output logic              ins_ready,
    input  logic              arg_valid,
    input  logic [DW-1:0]     arg_data,
    input  logic              start,
    input  logic [NCORES-1:0] core_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ack,
`ifdef GPU_CORE_PERF_EN
    output logic              ready,
    output logic [31:0]       perf_cycles
`else
    output logic              ready
`endif
);

    localparam int PW = $clog2(IMEM_DEPTH);  // PC width
    localparam int LW = PW + 1;              // wptr/plen width, holds IMEM_DEPTH

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_CGE  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_LD   = 4'hB;
    localparam logic [3:0] OP_MOVI = 4'hC;
    localparam logic [3:0] OP_ST   = 4'hD;
    localparam logic [3:0] OP_BNZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_F, S_D, S_E, S_M, S_MW, S_WB, S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_imem [IMEM_DEPTH];
    logic [DW-1:0]   r_rf [15];          // R0..R14; R15 is the core-id view
    logic [PW-1:0]   r_pc;
    logic [LW-1:0]   r_wptr, r_plen;
    logic [15:0]     r_ir;
    logic [DW-1:0]   r_a, r_b, r_c, r_res;
    logic            r_ready;
    logic            r_mem_req, r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;

    logic [3:0]      w_op, w_ra, w_rb, w_rd;
    logic [7:0]      w_imm8;
    logic            w_wr, w_launch, w_is_mem, w_taken, w_last, w_end, w_rf_wr;
    logic [LW-1:0]   w_wptr_nxt, w_plen_eff;
    logic [PW-1:0]   w_tgt;
    logic [2*DW-1:0] w_cat;
    logic [DW-1:0]   w_alu;

    assign w_op   = r_ir[15:12];
    assign w_ra   = r_ir[11:8];
    assign w_rb   = r_ir[7:4];
    assign w_rd   = r_ir[3:0];
    assign w_imm8 = r_ir[11:4];

    // Program loading: extra words beyond IMEM_DEPTH are dropped.
    assign w_wr       = (r_state == S_IDLE) && ins_valid && (r_wptr < LW'(IMEM_DEPTH));
    assign w_wptr_nxt = w_wr ? r_wptr + LW'(1) : r_wptr;
    // A word written in the launch cycle already counts towards the length.
    assign w_plen_eff = w_wr ? w_wptr_nxt : r_plen;
    assign w_launch   = (r_state == S_IDLE) && start && core_en[core_id];

    assign w_is_mem = (w_op == OP_LD) || (w_op == OP_ST);
    assign w_taken  = (w_op == OP_BNZ) && (r_a != '0);
    assign w_tgt    = PW'(w_imm8);
    assign w_cat    = {r_a, r_b};
    // Falling off the program end or the IMEM end both finish the run.
    assign w_last   = ({1'b0, r_pc} == r_plen - LW'(1)) || (r_pc == PW'(IMEM_DEPTH - 1));
    assign w_end    = (w_op == OP_HALT) || (!w_taken && w_last);
    assign w_rf_wr  = (w_rd != 4'hF) &&
                      (((w_op >= OP_ADD) && (w_op <= OP_XOR)) || (w_op == OP_LD) || (w_op == OP_MOVI));

    assign ins_ready = (r_state == S_IDLE);
    assign ready     = r_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Register read with R15 mapped to the zero-extended lane index.
    function automatic logic [DW-1:0] rf_rd(input logic [3:0] idx);
        if (idx == 4'hF) return DW'(core_id);
        return r_rf[idx];
    endfunction

    // ALU for all register-result opcodes; arithmetic wraps modulo 2**DW.
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_MUL:  w_alu = r_a * r_b;
            OP_DIV:  w_alu = (r_b == '0) ? '1 : r_a / r_b;
            OP_CGE:  w_alu = (r_a >= r_b) ? DW'(1) : '0;
            OP_SHR:  w_alu = r_a >> r_b[3:0];
            OP_SHL:  w_alu = r_a << r_b[3:0];
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            OP_XOR:  w_alu = r_a ^ r_b;
            OP_MOVI: w_alu = DW'(w_imm8);
            default: w_alu = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: one pass through the stages per instruction.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_launch) w_state_nxt = (w_plen_eff == '0) ? S_DONE : S_F;
            S_F:    w_state_nxt = S_D;
            S_D:    w_state_nxt = S_E;
            S_E:    w_state_nxt = S_M;
            S_M:    w_state_nxt = w_is_mem ? S_MW : S_WB;
            S_MW:   if (mem_ack) w_state_nxt = S_WB;
            S_WB:   w_state_nxt = w_end ? S_DONE : S_F;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Instruction memory write port (contents survive reset).
    always_ff @(posedge clk) begin
        if (w_wr) r_imem[r_wptr[PW-1:0]] <= ins_data;
    end

    // Register file: argument load while idle, result write-back in WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) r_rf[i] <= '0;
        end else if ((r_state == S_IDLE) && arg_valid) begin
            r_rf[0] <= arg_data;
        end else if ((r_state == S_WB) && w_rf_wr) begin
            r_rf[w_rd] <= r_res;
        end
    end

    // Datapath, sequencing and the memory handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= '0;
            r_wptr      <= '0;
            r_plen      <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_res       <= '0;
            r_ready     <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr) begin
                        r_wptr <= w_wptr_nxt;
                        r_plen <= w_wptr_nxt;
                    end
                    if (w_launch) begin
                        r_pc   <= '0;
                        r_wptr <= '0;
                        if (w_plen_eff != '0) r_ready <= 1'b0;
                    end
                end
                S_F: r_ir <= r_imem[r_pc];
                S_D: begin
                    r_a <= rf_rd(w_ra);
                    r_b <= rf_rd(w_rb);
                    r_c <= rf_rd(w_rd);
                end
                S_E: r_res <= w_alu;
                S_M: begin
                    if (w_is_mem) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_op == OP_ST);
                        r_mem_addr  <= AW'(w_cat);
                        r_mem_wdata <= r_c;
                    end
                end
                S_MW: begin
                    // Address/data stay put after the ack; only req/we drop.
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (w_op == OP_LD) r_res <= mem_rdata;
                    end
                end
                S_WB: if (!w_end) r_pc <= w_taken ? w_tgt : r_pc + PW'(1);
                S_DONE: r_ready <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef GPU_CORE_PERF_EN
    logic [31:0] r_perf;
    assign perf_cycles = r_perf;

    // Execution-cycle counter: cleared on launch, saturating, frozen when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_perf <= '0;
        else if (w_launch)
            r_perf <= '0;
        else if ((r_state != S_IDLE) && (r_state != S_DONE) && (r_perf != '1))
            r_perf <= r_perf + 32'd1;
    end
`endif

endmodule

// File: tb/tb_gpu_core_param.sv
// Directed bench for gpu_core_param: small programs, results observed via stores
// into a bench-side memory model that also drives the ack handshake.
module tb_gpu_core_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  core_id;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic        ins_ready;
    logic        arg_valid;
    logic [7:0]  arg_data;
    logic        start;
    logic [15:0] core_en;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        ready;

    gpu_core_param dut (
        .clk(clk), .reset(reset), .core_id(core_id),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_ready(ins_ready),
        .arg_valid(arg_valid), .arg_data(arg_data),
        .start(start), .core_en(core_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ready(ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] prog [0:15];
    logic [7:0]  tmem [0:4095];
    int          ack_delay = 0;
    int          req_cnt = 0, req_hi_cnt = 0, st_cnt = 0, stable_err = 0;
    logic        prev_req = 1'b0;
    logic [11:0] lat_addr, last_addr;
    logic [7:0]  lat_wdata, last_data;
    logic        lat_we, last_we;

    // Shared-memory model: acks after ack_delay waiting cycles, logs stores,
    // and checks the request stays stable while it is outstanding.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (reset) begin
            req_cnt  = 0;
            prev_req = 1'b0;
        end else begin
            if (mem_req) begin
                req_hi_cnt++;
                if (!prev_req) begin
                    lat_addr = mem_addr; lat_wdata = mem_wdata; lat_we = mem_we;
                end else if (mem_addr !== lat_addr || mem_wdata !== lat_wdata || mem_we !== lat_we) begin
                    stable_err++;
                end
                if (req_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    req_cnt = 0;
                    if (mem_we) begin
                        tmem[mem_addr] = mem_wdata;
                        st_cnt++;
                        last_addr = mem_addr; last_data = mem_wdata; last_we = mem_we;
                    end else begin
                        mem_rdata = tmem[mem_addr];
                    end
                end else begin
                    req_cnt++;
                end
            end else begin
                req_cnt = 0;
            end
            prev_req = mem_req;
        end
    end

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); ins_valid = 1'b1; ins_data = prog[i];
        end
        @(negedge clk); ins_valid = 1'b0;
    endtask

    task automatic set_arg(input logic [7:0] v);
        @(negedge clk); arg_valid = 1'b1; arg_data = v;
        @(negedge clk); arg_valid = 1'b0;
    endtask

    // Pulse start and count the cycles ready stays low.
    task automatic launch_wait(input logic [15:0] mask, output int cyc);
        @(negedge clk); core_en = mask; start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 0;
        while (ready === 1'b0 && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 2000) begin
            n_cmp++; n_err++;
            $display("FAIL launch_timeout: ready still low after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (ready !== 1'b1)       begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
        n_cmp++; if (ins_ready !== 1'b1)   begin n_err++; $display("FAIL rst_ins_ready: got %b want 1", ins_ready); end
        n_cmp++; if (mem_req !== 1'b0)     begin n_err++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0)      begin n_err++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 12'h0)   begin n_err++; $display("FAIL rst_mem_addr: got %h want 000", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'h0)   begin n_err++; $display("FAIL rst_mem_wdata: got %h want 00", mem_wdata); end
    endtask

    task automatic test_add();
        int cyc;
        prog[0] = 16'hC051; prog[1] = 16'hC032; prog[2] = 16'h1123; prog[3] = 16'hF000;
        load_prog(4);
        launch_wait(16'hFFFF, cyc);
        n_cmp++; if (cyc !== 21) begin n_err++; $display("FAIL add_ready_low: got %0d want 21", cyc); end
    endtask

    task automatic test_store();
        int cyc, st0, rh0, se0;
        st0 = st_cnt; rh0 = req_hi_cnt; se0 = stable_err;
        ack_delay = 3;
        prog[0] = 16'hD123; prog[1] = 16'hF000;
        load_prog(2);
        launch_wait(16'hFFFF, cyc);
        ack_delay = 0;
        n_cmp++; if (cyc !== 15) begin n_err++; $display("FAIL st_ready_low: got %0d want 15", cyc); end
        n_cmp++; if (req_hi_cnt - rh0 !== 4) begin n_err++; $display("FAIL st_req_cycles: got %0d want 4", req_hi_cnt - rh0); end
        n_cmp++; if (st_cnt - st0 !== 1) begin n_err++; $display("FAIL st_count: got %0d want 1", st_cnt - st0); end
        n_cmp++; if (last_addr !== 12'h503) begin n_err++; $display("FAIL st_addr: got %h want 503", last_addr); end
        n_cmp++; if (last_data !== 8'h08) begin n_err++; $display("FAIL st_data: got %h want 08", last_data); end
        n_cmp++; if (last_we !== 1'b1) begin n_err++; $display("FAIL st_we: got %b want 1", last_we); end
        n_cmp++; if (stable_err - se0 !== 0) begin n_err++; $display("FAIL st_stable: got %0d changes want 0", stable_err - se0); end
    endtask

    task automatic test_alu();
        int cyc, st0;
        set_arg(8'h00);
        st0 = st_cnt;
        prog[0]  = 16'hC051; prog[1]  = 16'hC032; prog[2]  = 16'h4103; prog[3]  = 16'h5214;
        prog[4]  = 16'hC815; prog[5]  = 16'hC016; prog[6]  = 16'h7567; prog[7]  = 16'hC109;
        prog[8]  = 16'hD893; prog[9]  = 16'hC119; prog[10] = 16'hD894; prog[11] = 16'hC129;
        prog[12] = 16'hD897; prog[13] = 16'hF000;
        load_prog(14);
        launch_wait(16'hFFFF, cyc);
        n_cmp++; if (st_cnt - st0 !== 3) begin n_err++; $display("FAIL alu_stores: got %0d want 3", st_cnt - st0); end
        n_cmp++; if (tmem[12'h010] !== 8'hFF) begin n_err++; $display("FAIL alu_div0: got %h want ff", tmem[12'h010]); end
        n_cmp++; if (tmem[12'h011] !== 8'h00) begin n_err++; $display("FAIL alu_cmpge: got %h want 00", tmem[12'h011]); end
        n_cmp++; if (tmem[12'h012] !== 8'h02) begin n_err++; $display("FAIL alu_shl: got %h want 02", tmem[12'h012]); end
    endtask

    // Full 16-word program without HALT: ends at plen-1; also covers LD.
    task automatic test_alu2();
        int cyc;
        prog[0]  = 16'h2213; prog[1]  = 16'h3154; prog[2]  = 16'h6566; prog[3]  = 16'h4127;
        prog[4]  = 16'hC109; prog[5]  = 16'hD893; prog[6]  = 16'hC119; prog[7]  = 16'hD894;
        prog[8]  = 16'hC129; prog[9]  = 16'hD896; prog[10] = 16'hC139; prog[11] = 16'hD897;
        prog[12] = 16'hC109; prog[13] = 16'hB89A; prog[14] = 16'hC149; prog[15] = 16'hD89A;
        load_prog(16);
        launch_wait(16'hFFFF, cyc);
        n_cmp++; if (tmem[12'h010] !== 8'hFE) begin n_err++; $display("FAIL alu_sub: got %h want fe", tmem[12'h010]); end
        n_cmp++; if (tmem[12'h011] !== 8'h85) begin n_err++; $display("FAIL alu_mul: got %h want 85", tmem[12'h011]); end
        n_cmp++; if (tmem[12'h012] !== 8'h40) begin n_err++; $display("FAIL alu_shr: got %h want 40", tmem[12'h012]); end
        n_cmp++; if (tmem[12'h013] !== 8'h01) begin n_err++; $display("FAIL alu_div: got %h want 01", tmem[12'h013]); end
        n_cmp++; if (tmem[12'h014] !== 8'hFE) begin n_err++; $display("FAIL ld_roundtrip: got %h want fe", tmem[12'h014]); end
    endtask

    task automatic test_disabled();
        int cyc, rh0, bad;
        prog[0] = 16'hC209; prog[1] = 16'hD891; prog[2] = 16'hC219; prog[3] = 16'hD89F;
        prog[4] = 16'hF000;
        load_prog(5);
        rh0 = req_hi_cnt; bad = 0;
        launch_wait(16'hFFF7, cyc);
        n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL dis_ready_low: got %0d want 0", cyc); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready !== 1'b1) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL dis_ready_held: got %0d low cycles want 0", bad); end
        n_cmp++; if (req_hi_cnt - rh0 !== 0) begin n_err++; $display("FAIL dis_no_req: got %0d want 0", req_hi_cnt - rh0); end
        launch_wait(16'h0008, cyc);
        n_cmp++; if (tmem[12'h020] !== 8'h05) begin n_err++; $display("FAIL en_store_r1: got %h want 05", tmem[12'h020]); end
        n_cmp++; if (tmem[12'h021] !== 8'h03) begin n_err++; $display("FAIL en_store_r15: got %h want 03", tmem[12'h021]); end
    endtask

    // Counter in R0 (BNZ tests R[ra], ra is the target's high nibble = 0).
    task automatic test_bnz();
        int cyc, st0;
        st0 = st_cnt;
        prog[0] = 16'hC309; prog[1] = 16'hC030; prog[2] = 16'hC012; prog[3] = 16'h2020;
        prog[4] = 16'hD890; prog[5] = 16'hE020;
        load_prog(6);
        launch_wait(16'hFFFF, cyc);
        n_cmp++; if (cyc !== 74) begin n_err++; $display("FAIL bnz_ready_low: got %0d want 74", cyc); end
        n_cmp++; if (st_cnt - st0 !== 3) begin n_err++; $display("FAIL bnz_iters: got %0d want 3", st_cnt - st0); end
        n_cmp++; if (tmem[12'h030] !== 8'h00) begin n_err++; $display("FAIL bnz_final: got %h want 00", tmem[12'h030]); end
    endtask

    task automatic test_reset_mid();
        int k, st0;
        st0 = st_cnt;
        ack_delay = 1000;
        prog[0] = 16'hD891; prog[1] = 16'hF000;
        load_prog(2);
        @(negedge clk); core_en = 16'hFFFF; start = 1'b1;
        @(negedge clk); start = 1'b0; k = 0;
        while (mem_req !== 1'b1 && k < 50) begin k++; @(negedge clk); end
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rm_req_seen: got %b want 1", mem_req); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (mem_req !== 1'b0)   begin n_err++; $display("FAIL rm_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (ready !== 1'b1)     begin n_err++; $display("FAIL rm_ready: got %b want 1", ready); end
        n_cmp++; if (ins_ready !== 1'b1) begin n_err++; $display("FAIL rm_idle: got %b want 1", ins_ready); end
        @(negedge clk); reset = 1'b0; ack_delay = 0;
        n_cmp++; if (st_cnt - st0 !== 0) begin n_err++; $display("FAIL rm_no_store: got %0d want 0", st_cnt - st0); end
    endtask

    initial begin
        reset = 1'b1; core_id = 4'd3; ins_valid = 1'b0; ins_data = 16'h0;
        arg_valid = 1'b0; arg_data = 8'h0; start = 1'b0; core_en = 16'h0;
        mem_rdata = 8'h0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_store();
        test_alu();
        test_alu2();
        test_disabled();
        test_bnz();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
